// File: rtl/vga_scanout.sv
// ============================================================================
// Module      : vga_scanout
// Description : Read-side master for the VGA port of the shared data memory.
//               Generates 640x480 VGA timing and walks an IMG_W x IMG_H
//               8-bit framebuffer anchored at the top-left of the screen.
//               The memory answers one clk after vga_addr; the pixel tick is
//               at least two clk apart, so the data is settled by the
//               following tick.
//
//               Ports:
//                 clk, rst            clock, asynchronous active-high reset
//                 pix_en              pixel tick (never on consecutive clk)
//                 vga_addr     [31:0] read address to memory VGA port
//                 out_data_vga [7:0]  memory read data (1 clk latency)
//                 hsync, vsync        active-low syncs
//                 blank_n             high while output pixel is visible
//                 vga_r/g/b    [7:0]  grey-replicated pixel colour
//                 frame_start         1-clk pulse when pixel (0,0) shows
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_scanout #(
  parameter int          H_VISIBLE = 640,
  parameter int          H_FP      = 16,
  parameter int          H_SYNC    = 96,
  parameter int          H_BP      = 48,
  parameter int          V_VISIBLE = 480,
  parameter int          V_FP      = 10,
  parameter int          V_SYNC    = 2,
  parameter int          V_BP      = 33,
  parameter int          IMG_W     = 256,
  parameter int          IMG_H     = 256,
  parameter logic [31:0] BASE_ADDR = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  output logic [31:0] vga_addr,
  input  logic [7:0]  out_data_vga,
  output logic        hsync,
  output logic        vsync,
  output logic        blank_n,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  // All region tests are done in 32 bits so that image sizes larger than
  // the counter range still compare correctly.
  localparam logic [31:0] c_H_LAST     = 32'(H_TOTAL - 1);
  localparam logic [31:0] c_V_LAST     = 32'(V_TOTAL - 1);
  localparam logic [31:0] c_H_VISIBLE  = 32'(H_VISIBLE);
  localparam logic [31:0] c_V_VISIBLE  = 32'(V_VISIBLE);
  localparam logic [31:0] c_IMG_W      = 32'(IMG_W);
  localparam logic [31:0] c_IMG_H      = 32'(IMG_H);
  localparam logic [31:0] c_HS_START   = 32'(H_VISIBLE + H_FP);
  localparam logic [31:0] c_HS_END     = 32'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [31:0] c_VS_START   = 32'(V_VISIBLE + V_FP);
  localparam logic [31:0] c_VS_END     = 32'(V_VISIBLE + V_FP + V_SYNC);

  // --------------------------------------------------------------------------
  // Position counters and per-line framebuffer base
  // --------------------------------------------------------------------------
  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic [31:0]   r_row_base;

  logic [31:0] w_h32;
  logic [31:0] w_v32;
  logic        w_h_last;
  logic        w_v_last;
  logic        w_vis;
  logic        w_in_img;
  logic        w_hs_act;
  logic        w_vs_act;
  logic        w_origin;
  logic [31:0] w_pix_addr;

  assign w_h32      = 32'(r_h_cnt);
  assign w_v32      = 32'(r_v_cnt);
  assign w_h_last   = (w_h32 == c_H_LAST);
  assign w_v_last   = (w_v32 == c_V_LAST);
  assign w_vis      = (w_h32 < c_H_VISIBLE) && (w_v32 < c_V_VISIBLE);
  assign w_in_img   = (w_h32 < c_IMG_W) && (w_v32 < c_IMG_H);
  assign w_hs_act   = (w_h32 >= c_HS_START) && (w_h32 < c_HS_END);
  assign w_vs_act   = (w_v32 >= c_VS_START) && (w_v32 < c_VS_END);
  assign w_origin   = (r_h_cnt == '0) && (r_v_cnt == '0);
  // Row base is accumulated line by line, so no multiplier is needed here.
  assign w_pix_addr = r_row_base + w_h32;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h_cnt    <= '0;
      r_v_cnt    <= '0;
      r_row_base <= BASE_ADDR;
    end else if (pix_en) begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        if (w_v_last) begin
          r_v_cnt    <= '0;
          r_row_base <= BASE_ADDR;
        end else begin
          r_v_cnt <= r_v_cnt + VW'(1);
          // Only image lines advance the base; below the image it parks.
          if (w_v32 < c_IMG_H) begin
            r_row_base <= r_row_base + c_IMG_W;
          end
        end
      end else begin
        r_h_cnt <= r_h_cnt + HW'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1: issue address, capture region flags for the same position
  // --------------------------------------------------------------------------
  logic [31:0] r_addr;
  logic        r_s1_vis;
  logic        r_s1_img;
  logic        r_s1_hs;
  logic        r_s1_vs;
  logic        r_s1_origin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr      <= BASE_ADDR;
      r_s1_vis    <= 1'b0;
      r_s1_img    <= 1'b0;
      r_s1_hs     <= 1'b0;
      r_s1_vs     <= 1'b0;
      r_s1_origin <= 1'b0;
    end else if (pix_en) begin
      // Outside the image the address holds, avoiding needless memory reads.
      if (w_in_img) begin
        r_addr <= w_pix_addr;
      end
      r_s1_vis    <= w_vis;
      r_s1_img    <= w_in_img;
      r_s1_hs     <= w_hs_act;
      r_s1_vs     <= w_vs_act;
      r_s1_origin <= w_origin;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: present pixel; syncs/blank delayed with data to stay aligned
  // --------------------------------------------------------------------------
  logic [7:0] r_pix;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_blank_n;
  logic       r_frame_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pix         <= 8'd0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_blank_n     <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      // pix_en is never high twice in a row, so this is a one-clk pulse.
      r_frame_start <= pix_en & r_s1_origin;
      if (pix_en) begin
        r_pix     <= (r_s1_vis && r_s1_img) ? out_data_vga : 8'd0;
        r_hsync   <= ~r_s1_hs;
        r_vsync   <= ~r_s1_vs;
        r_blank_n <= r_s1_vis;
      end
    end
  end

  assign vga_addr    = r_addr;
  assign vga_r       = r_pix;
  assign vga_g       = r_pix;
  assign vga_b       = r_pix;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign blank_n     = r_blank_n;
  assign frame_start = r_frame_start;

endmodule

`default_nettype wire

// File: tb/tb_vga_scanout.sv
// ============================================================================
// Module      : tb_vga_scanout
// Description : Self-checking bench for vga_scanout. Uses a reduced timing
//               geometry so whole frames fit in a short run. A reference
//               model of the scan position pushes the expected output of
//               each ticked position into a queue; the entry is popped and
//               compared when the DUT presents it one tick later.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_scanout;

  localparam int HV  = 40;
  localparam int HFP = 4;
  localparam int HSY = 6;
  localparam int HBP = 6;
  localparam int VV  = 20;
  localparam int VFP = 2;
  localparam int VSY = 2;
  localparam int VBP = 3;
  localparam int IW  = 16;
  localparam int IH  = 12;
  localparam logic [31:0] BASE = 32'd100;
  localparam int HT  = HV + HFP + HSY + HBP;
  localparam int VT  = VV + VFP + VSY + VBP;

  logic        clk;
  logic        rst;
  logic        pix_en;
  logic [31:0] vga_addr;
  logic [7:0]  out_data_vga;
  logic        hsync;
  logic        vsync;
  logic        blank_n;
  logic [7:0]  vga_r;
  logic [7:0]  vga_g;
  logic [7:0]  vga_b;
  logic        frame_start;

  vga_scanout #(
    .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .IMG_W(IW), .IMG_H(IH), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .vga_addr(vga_addr),
    .out_data_vga(out_data_vga), .hsync(hsync), .vsync(vsync),
    .blank_n(blank_n), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: registered read, returns low address byte.
  always @(posedge clk) out_data_vga <= vga_addr[7:0];

  typedef struct packed {
    logic       blank_n;
    logic       hsync;
    logic       vsync;
    logic [7:0] rgb;
    logic       fs;
  } exp_t;

  exp_t        q[$];
  int          m_h;
  int          m_v;
  logic [31:0] m_addr;
  int          checks;
  int          failures;

  task automatic model_reset();
    exp_t e;
    m_h    = 0;
    m_v    = 0;
    m_addr = BASE;
    q.delete();
    // First output after reset comes from cleared stage-1 flags.
    e.blank_n = 1'b0; e.hsync = 1'b1; e.vsync = 1'b1; e.rgb = 8'd0; e.fs = 1'b0;
    q.push_back(e);
  endtask

  // One pixel tick: idle clk, then pix_en for one clk. Returns at the
  // negedge following the update edge. Pushes expected output for the
  // position being ticked and advances the model position.
  task automatic pix_tick();
    exp_t e;
    bit vis, img, hs, vs;
    vis = (m_h < HV) && (m_v < VV);
    img = (m_h < IW) && (m_v < IH);
    hs  = (m_h >= HV + HFP) && (m_h < HV + HFP + HSY);
    vs  = (m_v >= VV + VFP) && (m_v < VV + VFP + VSY);
    if (img) m_addr = BASE + 32'(m_v * IW + m_h);
    e.blank_n = vis;
    e.hsync   = !hs;
    e.vsync   = !vs;
    e.rgb     = (vis && img) ? m_addr[7:0] : 8'd0;
    e.fs      = (m_h == 0) && (m_v == 0);
    q.push_back(e);
    if (m_h == HT - 1) begin
      m_h = 0;
      m_v = (m_v == VT - 1) ? 0 : m_v + 1;
    end else begin
      m_h = m_h + 1;
    end
    @(negedge clk);
    pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    repeat (10) begin
      pix_tick();
      e = q.pop_front();
    end
    // Asynchronous assertion between clock edges, mid-line.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (hsync !== 1'b1 || vsync !== 1'b1) begin
      failures++;
      $display("FAIL reset_sync got hsync=%b vsync=%b want 1 1", hsync, vsync);
    end
    checks++;
    if (blank_n !== 1'b0 || frame_start !== 1'b0) begin
      failures++;
      $display("FAIL reset_blank got blank_n=%b fs=%b want 0 0", blank_n, frame_start);
    end
    checks++;
    if ({vga_r, vga_g, vga_b} !== 24'h0) begin
      failures++;
      $display("FAIL reset_rgb got %h want 000000", {vga_r, vga_g, vga_b});
    end
    checks++;
    if (vga_addr !== BASE) begin
      failures++;
      $display("FAIL reset_addr got %0d want %0d", vga_addr, BASE);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    // First line: addresses in order; first output stale, (0,0) on 2nd tick.
    for (int i = 0; i < IW; i++) begin
      pix_tick();
      e = q.pop_front();
      checks++;
      if (vga_addr !== BASE + 32'(i)) begin
        failures++;
        $display("FAIL line0_addr i=%0d got %0d want %0d", i, vga_addr, BASE + 32'(i));
      end
      if (i == 0) begin
        checks++;
        if (blank_n !== 1'b0 || vga_r !== 8'd0) begin
          failures++;
          $display("FAIL first_out_stale got blank_n=%b r=%0d want 0 0", blank_n, vga_r);
        end
      end
      if (i == 1) begin
        checks++;
        if (frame_start !== 1'b1 || vga_r !== BASE[7:0] || blank_n !== 1'b1) begin
          failures++;
          $display("FAIL origin_out got fs=%b r=%0d blank_n=%b want 1 %0d 1",
                   frame_start, vga_r, blank_n, BASE[7:0]);
        end
      end
    end
  endtask

  task automatic test_frame();
    exp_t e;
    int   ph, pv;
    int   fs_cnt, hs_low, vs_low, bl_hi;
    fs_cnt = 0; hs_low = 0; vs_low = 0; bl_hi = 0;
    for (int n = 0; n < 2 * HT * VT; n++) begin
      ph = m_h;
      pv = m_v;
      pix_tick();
      e = q.pop_front();
      checks++;
      if (vga_addr !== m_addr) begin
        failures++;
        $display("FAIL addr pos=(%0d,%0d) got %0d want %0d", ph, pv, vga_addr, m_addr);
      end
      checks++;
      if (blank_n !== e.blank_n || hsync !== e.hsync || vsync !== e.vsync) begin
        failures++;
        $display("FAIL timing pos=(%0d,%0d) got b/h/v=%b%b%b want %b%b%b", ph, pv,
                 blank_n, hsync, vsync, e.blank_n, e.hsync, e.vsync);
      end
      checks++;
      if (vga_r !== e.rgb || vga_g !== e.rgb || vga_b !== e.rgb) begin
        failures++;
        $display("FAIL rgb pos=(%0d,%0d) got %0d/%0d/%0d want %0d", ph, pv,
                 vga_r, vga_g, vga_b, e.rgb);
      end
      checks++;
      if (frame_start !== e.fs) begin
        failures++;
        $display("FAIL frame_start pos=(%0d,%0d) got %b want %b", ph, pv, frame_start, e.fs);
      end
      if (ph == IW - 1 && pv == IH - 1) begin
        checks++;
        if (vga_addr !== BASE + 32'(IW * IH - 1)) begin
          failures++;
          $display("FAIL last_img_addr got %0d want %0d", vga_addr, BASE + 32'(IW * IH - 1));
        end
      end
      if (frame_start === 1'b1) fs_cnt++;
      if (hsync === 1'b0) hs_low++;
      if (vsync === 1'b0) vs_low++;
      if (blank_n === 1'b1) bl_hi++;
      if (e.fs) begin
        @(negedge clk);
        checks++;
        if (frame_start !== 1'b0) begin
          failures++;
          $display("FAIL fs_width got %b want 0", frame_start);
        end
      end
    end
    checks++;
    if (fs_cnt != 2) begin
      failures++;
      $display("FAIL fs_count got %0d want 2", fs_cnt);
    end
    checks++;
    if (hs_low != 2 * VT * HSY) begin
      failures++;
      $display("FAIL hsync_low_count got %0d want %0d", hs_low, 2 * VT * HSY);
    end
    checks++;
    if (vs_low != 2 * VSY * HT) begin
      failures++;
      $display("FAIL vsync_low_count got %0d want %0d", vs_low, 2 * VSY * HT);
    end
    checks++;
    if (bl_hi != 2 * HV * VV) begin
      failures++;
      $display("FAIL blank_hi_count got %0d want %0d", bl_hi, 2 * HV * VV);
    end
  endtask

  task automatic test_stall();
    exp_t        e;
    logic [63:0] snap;
    while (m_h != 7) begin
      pix_tick();
      e = q.pop_front();
    end
    snap = {vga_addr, vga_r, vga_g, vga_b, hsync, vsync, blank_n, frame_start, 4'h0};
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checks++;
      if ({vga_addr, vga_r, vga_g, vga_b, hsync, vsync, blank_n, frame_start, 4'h0} !== snap) begin
        failures++;
        $display("FAIL stall_hold clk=%0d got %h want %h", i,
                 {vga_addr, vga_r, vga_g, vga_b, hsync, vsync, blank_n, frame_start, 4'h0}, snap);
      end
    end
    for (int n = 0; n < 2 * HT; n++) begin
      pix_tick();
      e = q.pop_front();
      checks++;
      if (vga_addr !== m_addr || vga_r !== e.rgb || blank_n !== e.blank_n || hsync !== e.hsync) begin
        failures++;
        $display("FAIL after_stall n=%0d got a=%0d r=%0d b=%b h=%b want a=%0d r=%0d b=%b h=%b",
                 n, vga_addr, vga_r, blank_n, hsync, m_addr, e.rgb, e.blank_n, e.hsync);
      end
    end
  endtask

  task automatic test_reset_midframe();
    exp_t e;
    while (m_v != VV / 2 || m_h != 5) begin
      pix_tick();
      e = q.pop_front();
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (vga_addr !== BASE || blank_n !== 1'b0 || hsync !== 1'b1 || vga_r !== 8'd0) begin
      failures++;
      $display("FAIL midframe_rst got a=%0d b=%b h=%b r=%0d want %0d 0 1 0",
               vga_addr, blank_n, hsync, vga_r, BASE);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int n = 0; n < HT; n++) begin
      pix_tick();
      e = q.pop_front();
      checks++;
      if (vga_addr !== m_addr || vga_r !== e.rgb || blank_n !== e.blank_n ||
          frame_start !== e.fs) begin
        failures++;
        $display("FAIL restart n=%0d got a=%0d r=%0d b=%b fs=%b want a=%0d r=%0d b=%b fs=%b",
                 n, vga_addr, vga_r, blank_n, frame_start, m_addr, e.rgb, e.blank_n, e.fs);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    pix_en   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    test_reset();
    test_frame();
    test_stall();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vga_scanout.md
# vga_scanout

Read-side master for the VGA port of the shared data memory. It generates 640x480 VGA timing and the `vga_addr` sequence for an `IMG_W`x`IMG_H` 8-bit framebuffer placed at the top-left of the screen. It consumes `out_data_vga`, which has one-cycle registered read latency, and drives sync, blank and grey-replicated RGB outputs. The CPU write port of the memory is untouched.

## Interface
Parameters:
- `H_VISIBLE`, 640, visible pixels per line
- `H_FP` / `H_SYNC` / `H_BP`, 16 / 96 / 48, horizontal front porch / sync / back porch
- `V_VISIBLE`, 480, visible lines
- `V_FP` / `V_SYNC` / `V_BP`, 10 / 2 / 33, vertical front porch / sync / back porch
- `IMG_W` / `IMG_H`, 256 / 256, framebuffer size in pixels (1 byte per pixel)
- `BASE_ADDR`, 0, byte address of framebuffer pixel (0,0)

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `pix_en`  in  1  pixel tick; never high on two consecutive `clk` cycles
- `vga_addr`  out  32  read address to the memory VGA port
- `out_data_vga`  in  8  memory read data, valid one `clk` after `vga_addr`
- `hsync` / `vsync`  out  1  active-low syncs
- `blank_n`  out  1  high while output pixel is in the visible region
- `vga_r` / `vga_g` / `vga_b`  out  8  pixel colour
- `frame_start`  out  1  one-`clk` pulse when pixel (0,0) is presented

## Operation
- Counters: `h_cnt` covers 0..H_TOTAL-1, where H_TOTAL = 800. `v_cnt` covers 0..V_TOTAL-1, where V_TOTAL = 525.
  - Counters advance only on `pix_en`.
  - `h_cnt` wraps to 0 at H_TOTAL-1 and increments `v_cnt`.
  - `v_cnt` wraps to 0 at V_TOTAL-1.
- Region flags, computed from the counters:
  - `vis` = `h_cnt`<H_VISIBLE and `v_cnt`<V_VISIBLE.
  - `in_img` = `h_cnt`<IMG_W and `v_cnt`<IMG_H.
  - `hs_act` = `h_cnt` in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1].
  - `vs_act` = the same test on `v_cnt` with the V parameters.
- Addressing (no multiplier):
  - A `row_base` register holds BASE_ADDR at `v_cnt`=0.
  - At each line wrap with `v_cnt`<IMG_H, `row_base` increases by IMG_W.
  - The pixel address is `row_base` + `h_cnt`, 32-bit modulo arithmetic.
- Stage 1, on `pix_en`:
  - If `in_img`, `vga_addr` <= pixel address; otherwise `vga_addr` holds its last value.
  - Register `vis`, `in_img`, `hs_act`, `vs_act` and the (0,0) flag.
- Stage 2, on the next `pix_en`:
  - `vga_r`/`vga_g`/`vga_b` <= `out_data_vga` if stage-1 `vis` and `in_img`, else 0.
  - `hsync` <= !`hs_act`; `vsync` <= !`vs_act`; `blank_n` <= `vis`, all taken from stage 1.
- `frame_start` is high for the single `clk` cycle after the stage-2 update that presents pixel (0,0).
- With `pix_en` held low, the counters, address and all outputs freeze.
- No state machine beyond the counters and the 2-stage pipeline.

## Timing
- Reset values (asynchronous, while `rst`=1):
  - `h_cnt` = `v_cnt` = 0; `row_base` = BASE_ADDR; `vga_addr` = BASE_ADDR.
  - `hsync` = `vsync` = 1; `blank_n` = 0; RGB = 0; `frame_start` = 0.
  - All stage-1 flags cleared.
- Latency: counter position P drives `vga_addr` after pix_en tick k. The outputs for P appear after tick k+1. Syncs, blank and RGB stay mutually aligned.
- The memory needs 1 `clk` after the address. The ≥2-`clk` `pix_en` spacing guarantees `out_data_vga` is stable at tick k+1.
- Reset de-asserted mid-frame: the next `pix_en` restarts the sequence at (0,0). The first output after that is stale-cleared, and the outputs for (0,0) appear on the 2nd tick.
- Last image pixel: address BASE_ADDR + IMG_W*IMG_H - 1.
- If IMG_W>H_VISIBLE or IMG_H>V_VISIBLE, addresses outside the visible region are still issued, but the RGB for them is forced to 0.

## Test plan
- Reset: assert `rst` mid-line → immediately `hsync`=`vsync`=1, `blank_n`=0, RGB=0, `vga_addr`=0. Release, then `pix_en` every 2nd `clk` → first line addresses 0,1,…,255 in order.
- Memory model returning `addr[7:0]`, default parameters → line 0 outputs RGB=0..255 with `blank_n`=1. Pixels 256..639 give RGB=0 with `blank_n`=1, and `vga_addr` holds 255.
- Horizontal timing → `hsync` low for exactly 96 ticks, starting at output pixel 656. `blank_n`=0 from output pixel 640 to 799. Line period 800 ticks.
- Line 1 → addresses 256..511; line 255 ends at 65535. Line 256 onward → RGB=0 and `vga_addr` frozen at 65535.
- Frame → `vsync` low for 2 lines starting at line 490. After 525 lines the address restarts at 0 and `frame_start` pulses exactly once per frame.
- Stall → `pix_en` low for 50 `clk` mid-line, and all outputs and `vga_addr` stay constant. `rst` pulse for 1 `clk` mid-frame → the sequence restarts at (0,0).
